mux_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 8:1 multiplexer (eight_x_one_mux) between 8 requesters.
- Drives the mux select and a one-hot grant vector.
- Holds the grant until the owner releases it.
- Sits directly ahead of the mux. The mux output is valid to downstream logic only while `valid` is high.

---
 rtl/mux_rr_arbiter.sv | 134 +++++++++++++
 tb/tb_mux_rr_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the select of an 8:1 mux; grant is held until the owner releases it.
// Optional forced revoke after MAX_HOLD cycles is enabled by defining MUX_ARB_TIMEOUT_EN.
module mux_rr_arbiter #(
  parameter int N        = 8,
  parameter int SEL_W    = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] sel,
  output logic             valid,
  output logic             timeout
);

  if (N != 8 || SEL_W != 3 || MAX_HOLD < 1 || MAX_HOLD > 256) begin : g_bad_cfg
    $error("mux_rr_arbiter: unsupported parameter set");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] search_base;
  logic [SEL_W-1:0] win;
  logic             any_req;
  logic             release_c;
  logic             expire;

  // Index arithmetic wraps naturally because N is exactly 2**SEL_W.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [SEL_W-1:0] base,
                                                input logic [N-1:0]     r);
    logic [SEL_W-1:0] pick;
    logic [SEL_W-1:0] idx;
    pick = base;
    for (int j = N - 1; j >= 0; j--) begin
      idx = base + SEL_W'(j);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  // After a release the search starts just past the owner, so the owner is checked last.
  assign search_base = (state_q == GRANT) ? sel_q + SEL_W'(1) : ptr_q;
  assign win         = rr_pick(search_base, req);
  assign any_req     = |req;
  assign release_c   = done | ~req[sel_q];

`ifdef MUX_ARB_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;
  logic       timeout_q, timeout_d;

  assign expire    = (state_q == GRANT) && !release_c && (hold_q == 8'(MAX_HOLD - 1));
  assign hold_d    = ((state_q == GRANT) && !release_c && !expire) ? hold_q + 8'd1 : 8'd0;
  assign timeout_d = expire;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          grant_d = N'(1) << win;
          sel_d   = win;
          valid_d = 1'b1;
        end
      end
      GRANT: begin
        if (release_c || expire) begin
          ptr_d = sel_q + SEL_W'(1);
          if (any_req) begin
            grant_d = N'(1) << win;
            sel_d   = win;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
    end
  end

  assign grant = grant_q;
  assign sel   = sel_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_mux_rr_arbiter;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif
  localparam int MAX_HOLD = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       valid;
  logic       timeout;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Behavioural model: owner index (-1 when idle), priority pointer, hold length.
  int   m_owner;
  int   m_ptr;
  int   m_hold;
  int   m_sel;
  logic m_tmo;

  mux_rr_arbiter #(.N(8), .SEL_W(3), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .grant(grant), .sel(sel), .valid(valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic int search(input int from, input logic [7:0] r);
    for (int j = 0; j < 8; j++)
      if (r[(from + j) % 8]) return (from + j) % 8;
    return -1;
  endfunction

  function automatic logic [12:0] expected();
    logic [7:0] g;
    g = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
    return {g, 3'(m_sel), (m_owner >= 0), m_tmo};
  endfunction

  task automatic step(input logic [7:0] r, input logic d, input logic rs);
    bit rel;
    bit to;
    req = r; done = d; rst = rs;
    @(posedge clk); #1;
    if (rs) begin
      m_owner = -1; m_ptr = 0; m_hold = 0; m_sel = 0; m_tmo = 1'b0;
    end else if (m_owner < 0) begin
      m_tmo = 1'b0;
      if (r != 8'h00) begin
        m_owner = search(m_ptr, r); m_sel = m_owner; m_hold = 0;
      end
    end else begin
      rel   = d || !r[m_owner];
      to    = TMO && !rel && (m_hold == MAX_HOLD - 1);
      m_tmo = to;
      if (rel || to) begin
        m_ptr = (m_owner + 1) % 8;
        if (r != 8'h00) begin
          m_owner = search(m_ptr, r); m_sel = m_owner; m_hold = 0;
        end else begin
          m_owner = -1;
        end
      end else begin
        m_hold++;
      end
    end
  endtask

  task automatic test_reset();
    step(8'hFF, 1'b0, 1'b1);
    step(8'hFF, 1'b0, 1'b1);
    total_cnt++;
    if ({grant, sel, valid, timeout} !== {8'h00, 3'd0, 1'b0, 1'b0})
      $display("FAIL reset_state got g=%h s=%0d v=%b t=%b want g=00 s=0 v=0 t=0", grant, sel, valid, timeout);
    else pass_cnt++;
    step(8'hFF, 1'b0, 1'b0);
    total_cnt++;
    if ({grant, sel, valid} !== {8'h01, 3'd0, 1'b1})
      $display("FAIL reset_first_grant got g=%h s=%0d v=%b want g=01 s=0 v=1", grant, sel, valid);
    else pass_cnt++;
  endtask

  task automatic test_single();
    step(8'h00, 1'b0, 1'b1);
    step(8'h20, 1'b0, 1'b0);
    total_cnt++;
    if ({grant, sel, valid} !== {8'h20, 3'd5, 1'b1})
      $display("FAIL single_grant got g=%h s=%0d v=%b want g=20 s=5 v=1", grant, sel, valid);
    else pass_cnt++;
    step(8'h00, 1'b1, 1'b0);
    total_cnt++;
    if ({grant, sel, valid} !== {8'h00, 3'd5, 1'b0})
      $display("FAIL single_release got g=%h s=%0d v=%b want g=00 s=5 v=0", grant, sel, valid);
    else pass_cnt++;
    step(8'h00, 1'b1, 1'b0);
    total_cnt++;
    if ({grant, valid} !== {8'h00, 1'b0})
      $display("FAIL idle_done_ignored got g=%h v=%b want g=00 v=0", grant, valid);
    else pass_cnt++;
  endtask

  task automatic test_rotation();
    step(8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      step(8'hFF, 1'b1, 1'b0);
      total_cnt++;
      if ({sel, valid, grant} !== {3'(i % 8), 1'b1, 8'h01 << (i % 8)})
        $display("FAIL rotation_%0d got s=%0d v=%b g=%h want s=%0d v=1", i, sel, valid, grant, i % 8);
      else pass_cnt++;
    end
  endtask

  task automatic test_wrap_skip();
    step(8'h00, 1'b0, 1'b1);
    step(8'h40, 1'b0, 1'b0);
    step(8'h05, 1'b1, 1'b0);
    total_cnt++;
    if ({grant, sel} !== {8'h01, 3'd0})
      $display("FAIL wrap_to_0 got g=%h s=%0d want g=01 s=0", grant, sel);
    else pass_cnt++;
    step(8'h05, 1'b1, 1'b0);
    total_cnt++;
    if ({grant, sel} !== {8'h04, 3'd2})
      $display("FAIL skip_to_2 got g=%h s=%0d want g=04 s=2", grant, sel);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    step(8'h00, 1'b0, 1'b1);
    step(8'h08, 1'b0, 1'b0);
    step(8'hFF, 1'b0, 1'b0);
    total_cnt++;
    if ({grant, sel} !== {8'h08, 3'd3})
      $display("FAIL mid_reset_owner got g=%h s=%0d want g=08 s=3", grant, sel);
    else pass_cnt++;
    step(8'hFF, 1'b0, 1'b1);
    total_cnt++;
    if ({grant, valid} !== {8'h00, 1'b0})
      $display("FAIL mid_reset_drop got g=%h v=%b want g=00 v=0", grant, valid);
    else pass_cnt++;
    step(8'hFF, 1'b0, 1'b0);
    total_cnt++;
    if ({grant, sel} !== {8'h01, 3'd0})
      $display("FAIL mid_reset_ptr got g=%h s=%0d want g=01 s=0", grant, sel);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int held;
    int bad;
    held = 0; bad = 0;
    step(8'h00, 1'b0, 1'b1);
    step(8'h03, 1'b0, 1'b0);
    if (TMO) begin
      while (grant == 8'h01 && held < 40) begin
        held++;
        if (timeout !== 1'b0) bad++;
        step(8'h03, 1'b0, 1'b0);
      end
      total_cnt++;
      if (held !== 16 || bad !== 0)
        $display("FAIL timeout_hold_len got %0d cycles (%0d early pulses) want 16", held, bad);
      else pass_cnt++;
      total_cnt++;
      if ({timeout, grant} !== {1'b1, 8'h02})
        $display("FAIL timeout_handoff got t=%b g=%h want t=1 g=02", timeout, grant);
      else pass_cnt++;
      step(8'h03, 1'b0, 1'b0);
      total_cnt++;
      if ({timeout, grant} !== {1'b0, 8'h02})
        $display("FAIL timeout_pulse_width got t=%b g=%h want t=0 g=02", timeout, grant);
      else pass_cnt++;
    end else begin
      for (int i = 0; i < 110; i++) begin
        if (grant !== 8'h01 || timeout !== 1'b0) bad++;
        step(8'h03, 1'b0, 1'b0);
      end
      total_cnt++;
      if (bad !== 0 || grant !== 8'h01)
        $display("FAIL hold_forever got %0d bad cycles, final g=%h want 0 bad, g=01", bad, grant);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [7:0]  r;
    logic [12:0] exp_v;
    int          errs;
    int          inv_errs;
    errs = 0; inv_errs = 0;
    step(8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      r = (i % 3 == 0) ? 8'($urandom) : 8'($urandom & $urandom & $urandom);
      step(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 80) == 0));
      exp_v = expected();
      total_cnt++;
      if ({grant, sel, valid, timeout} !== exp_v) begin
        errs++;
        if (errs <= 10)
          $display("FAIL random_%0d got g=%h s=%0d v=%b t=%b want g=%h s=%0d v=%b t=%b",
                   i, grant, sel, valid, timeout, exp_v[12:5], exp_v[4:2], exp_v[1], exp_v[0]);
      end else pass_cnt++;
      if ($countones(grant) > 1 || (valid && grant !== (8'h01 << sel)) || (valid !== (grant != 8'h00)))
        inv_errs++;
    end
    total_cnt++;
    if (inv_errs !== 0)
      $display("FAIL invariants got %0d violating cycles want 0", inv_errs);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; req = 8'h00; done = 1'b0;
    m_owner = -1; m_ptr = 0; m_hold = 0; m_sel = 0; m_tmo = 1'b0;
    test_reset();
    test_single();
    test_rotation();
    test_wrap_skip();
    test_mid_reset();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
